// File: rtl/switch_poll_pkg.sv
// Shared types and helpers for the switch poll master.
package switch_poll_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    CMP     = 3'd3,
    WR_REQ  = 3'd4
  } state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic int cnt_width(input int div);
    return ($clog2(div) < 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/switch_poll_master_poll_timer.sv
// Poll interval down-counter: decrements on tick, reloads on the tick that finds it at zero.
module poll_timer
  import switch_poll_pkg::*;
#(
  parameter int DIV = 8,
  parameter int W   = cnt_width(DIV)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  output logic zero
);

  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) cnt_d = zero ? RELOAD : cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= RELOAD;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/switch_poll_master.sv
// Avalon-MM initiator: polls the switch PIO and mirrors changed values to the output PIO.
//   state   | meaning
//   IDLE    | counting down to the next poll (only while enable=1)
//   RD_REQ  | read command presented, waiting for waitrequest=0
//   RD_WAIT | read accepted, waiting for readdatavalid
//   CMP     | compare sample with last value, launch write if changed/first
//   WR_REQ  | write command presented, waiting for waitrequest=0
module switch_poll_master
  import switch_poll_pkg::*;
#(
  parameter int          POLL_DIV = 50000,
  parameter logic [31:0] SRC_ADDR = 32'h0000_0000,
  parameter logic [31:0] DST_ADDR = 32'h0000_0010,
  parameter int          DATA_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [31:0]       avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] sw_value,
  output logic              sw_changed
);

  state_e            state_q, state_d;
  logic              read_q, read_d, write_q, write_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [DATA_W-1:0] sw_value_q, sw_value_d, sample_q, sample_d;
  logic              changed_q, changed_d, first_q, first_d;
  logic              tick, cnt_zero, start;
  logic              unused_rd;

  assign unused_rd = ^avm_readdata;
  assign tick      = (state_q == IDLE) && enable;
  assign start     = tick && cnt_zero;

  poll_timer #(.DIV(POLL_DIV)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sw_value_d = sw_value_q;
    sample_d   = sample_q;
    first_d    = first_q;
    changed_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = SRC_ADDR;
        read_d  = 1'b1;
        state_d = RD_REQ;
      end
      RD_REQ: if (!avm_waitrequest) begin
        read_d = 1'b0;
        // a zero-latency slave returns data in the accept cycle
        if (avm_readdatavalid) begin
          sample_d = avm_readdata[DATA_W-1:0];
          state_d  = CMP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (avm_readdatavalid) begin
        sample_d = avm_readdata[DATA_W-1:0];
        state_d  = CMP;
      end
      CMP: if (first_q || (sample_q != sw_value_q)) begin
        sw_value_d = sample_q;
        changed_d  = 1'b1;
        first_d    = 1'b0;
        addr_d     = DST_ADDR;
        wdata_d    = 32'(sample_q);
        write_d    = 1'b1;
        state_d    = WR_REQ;
      end else begin
        state_d = IDLE;
      end
      WR_REQ: if (!avm_waitrequest) begin
        write_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sw_value_q <= '0;
      sample_q   <= '0;
      changed_q  <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sw_value_q <= sw_value_d;
      sample_q   <= sample_d;
      changed_q  <= changed_d;
      first_q    <= first_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = BE_ALL;
  assign sw_value       = sw_value_q;
  assign sw_changed     = changed_q;

endmodule

// File: tb/tb_switch_poll_master.sv
// Bench for switch_poll_master: table of polls plus enable/reset corner sequences.
module tb_switch_poll_master;

  localparam int          POLL_DIV = 8;
  localparam logic [31:0] SRC      = 32'h0000_0000;
  localparam logic [31:0] DST      = 32'h0000_0010;

  typedef struct {
    logic [31:0] data;
    int          rd_wait;
    int          wr_wait;
    bit          zl;
    bit          drop_en;
    bit          rst_wr;
    bit          exp_write;
    logic [3:0]  exp_val;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_read, avm_write, sw_changed;
  logic [3:0]  avm_byteenable, sw_value;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  switch_poll_master #(
    .POLL_DIV(POLL_DIV), .SRC_ADDR(SRC), .DST_ADDR(DST), .DATA_W(4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .sw_value          (sw_value),
    .sw_changed        (sw_changed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_read(output int rise);
    rise = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (avm_read) begin
        rise = cyc;
        break;
      end
    end
    if (rise < 0) begin
      checks++;
      errors++;
      $display("FAIL read_timeout actual=no_read required=read (cycle %0d)", cyc);
    end
  endtask

  task automatic drive_rdv(input vec_t v);
    avm_readdatavalid = 1'b1;
    avm_readdata      = v.data;
    if (v.exp_write) exp_q.push_back({28'h0, v.exp_val});
  endtask

  task automatic do_poll(input vec_t v, input int exp_rise, output int entry);
    int          rise;
    logic [31:0] wd;
    wait_read(rise);
    chk("read_start_cycle", rise, exp_rise);
    chk("read_addr", avm_address, SRC);
    chk("read_write_exclusive", avm_write, 1'b0);
    chk("byteenable", {28'h0, avm_byteenable}, 32'hF);
    avm_waitrequest = (v.rd_wait > 0);
    if (v.zl && v.rd_wait == 0) drive_rdv(v);
    for (int i = 1; i <= v.rd_wait; i++) begin
      @(negedge clk);
      chk("read_held", avm_read, 1'b1);
      chk("read_addr_held", avm_address, SRC);
      if (i == v.rd_wait) begin
        avm_waitrequest = 1'b0;
        if (v.zl) drive_rdv(v);
      end
    end
    @(negedge clk);
    chk("read_dropped", avm_read, 1'b0);
    if (v.zl) begin
      avm_readdatavalid = 1'b0;
    end else begin
      drive_rdv(v);
      if (v.drop_en) enable = 1'b0;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
    end
    avm_readdata = $urandom;
    @(negedge clk);
    if (v.exp_write) begin
      chk("write_start", avm_write, 1'b1);
      chk("write_addr", avm_address, DST);
      chk("write_data", avm_writedata, {28'h0, v.exp_val});
      chk("changed_pulse", sw_changed, 1'b1);
      chk("sw_value_update", {28'h0, sw_value}, {28'h0, v.exp_val});
      avm_waitrequest = (v.wr_wait > 0) || v.rst_wr;
      if (v.rst_wr) begin
        @(negedge clk);
        chk("write_held_before_reset", avm_write, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("reset_async_write", avm_write, 1'b0);
        chk("reset_async_read", avm_read, 1'b0);
        chk("reset_async_addr", avm_address, 32'h0);
        chk("reset_async_sw_value", {28'h0, sw_value}, 32'h0);
        exp_q.delete();
        avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        entry   = cyc;
      end else begin
        for (int i = 1; i <= v.wr_wait; i++) begin
          @(negedge clk);
          chk("write_held", avm_write, 1'b1);
          chk("write_addr_held", avm_address, DST);
          chk("write_data_held", avm_writedata, {28'h0, v.exp_val});
          chk("changed_single_cycle", sw_changed, 1'b0);
          if (i == v.wr_wait) avm_waitrequest = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=write required=none (cycle %0d)", cyc);
        end else begin
          wd = exp_q.pop_front();
          chk("write_scoreboard", avm_writedata, wd);
        end
        entry = cyc + 1;
        @(negedge clk);
        chk("write_dropped", avm_write, 1'b0);
        chk("changed_cleared", sw_changed, 1'b0);
      end
    end else begin
      chk("no_write", avm_write, 1'b0);
      chk("no_changed", sw_changed, 1'b0);
      chk("sw_value_kept", {28'h0, sw_value}, {28'h0, v.exp_val});
      entry = cyc;
    end
  endtask

  vec_t tbl[8];
  vec_t v_drop, v_same, v_rst, v_after;

  initial begin
    int entry;
    int reads;
    tbl[0] = '{32'h0000_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5};
    tbl[1] = '{32'h0000_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
    tbl[2] = '{32'h0000_000A, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA};
    tbl[3] = '{32'h0000_0006, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6};
    tbl[4] = '{32'hFFFF_FFF3, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3};
    tbl[5] = '{32'h0000_0013, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3};
    tbl[6] = '{32'h0000_0000, 2, 3, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[7] = '{32'h0000_0007, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7};
    v_drop  = '{32'h0000_0009, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h9};
    v_same  = '{32'h0000_0009, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9};
    v_rst   = '{32'h0000_000C, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hC};
    v_after = '{32'h0000_000C, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC};

    repeat (3) @(negedge clk);
    chk("rst_read", avm_read, 1'b0);
    chk("rst_write", avm_write, 1'b0);
    chk("rst_addr", avm_address, 32'h0);
    chk("rst_wdata", avm_writedata, 32'h0);
    chk("rst_sw_value", {28'h0, sw_value}, 32'h0);
    chk("rst_changed", sw_changed, 1'b0);
    reset_n = 1'b1;
    entry   = cyc;

    for (int i = 0; i < 8; i++) do_poll(tbl[i], entry + POLL_DIV, entry);

    // enable drops while waiting for read data
    do_poll(v_drop, entry + POLL_DIV, entry);
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_read) reads++;
      avm_readdatavalid = (i == 8);
      avm_readdata      = (i == 8) ? 32'h0000_000F : 32'h0;
    end
    chk("no_read_while_disabled", reads, 0);
    chk("stray_rdv_ignored", {28'h0, sw_value}, 32'h9);
    enable = 1'b1;
    entry  = cyc;
    do_poll(v_same, entry + POLL_DIV, entry);

    // enable drops in IDLE after three counted cycles; the count must resume
    repeat (3) @(negedge clk);
    enable = 1'b0;
    reads  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (avm_read) reads++;
    end
    chk("no_read_idle_frozen", reads, 0);
    enable = 1'b1;
    do_poll(v_same, entry + POLL_DIV + 10, entry);

    do_poll(v_rst, entry + POLL_DIV, entry);
    do_poll(v_after, entry + POLL_DIV, entry);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
